// File: rtl/clk_div_monitor_pkg.sv
// Shared types and default sizing for the divided-clock monitor.
package clk_div_monitor_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_LOCK_CNT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_monitor_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high phase of an asynchronous divided clock and tracks lock
// against an expected period, flagging mismatches and stuck-clock timeouts.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
  input  logic [CNT_W-1:0] expected_period,
  input  logic             clear,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  logic             w_sync;
  logic             r_prev;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_match;
  state_t           r_state;

  logic w_active;
  logic w_exp_zero;
  logic w_match;
  logic w_period_err;
  logic w_timeout;
  logic w_err;
  logic w_lock_hit;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (div_clk_in),
    .o_q   (w_sync)
  );

  // Edge-detect history is part of the synchronizer path, so clear leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_sync;
  end

  assign w_active     = (r_state != ST_IDLE);
  assign w_exp_zero   = (expected_period == '0);
  assign w_match      = (r_cnt == expected_period);
  assign w_period_err = r_rise && w_active && !w_exp_zero && !w_match;
  assign w_timeout    = !r_rise && w_active && (r_cnt == '1);
  assign w_err        = w_period_err || w_timeout;
  assign w_lock_hit   = ((r_match + CNT_W'(1)) >= CNT_W'(LOCK_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_cnt       <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_match     <= '0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_cnt       <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_match     <= '0;
    end else begin
      r_rise  <= w_sync & ~r_prev;
      r_fall  <= ~w_sync & r_prev;
      r_valid <= 1'b0;
      r_err   <= w_err;

      if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);

      if (r_rise)              r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)    r_cnt <= r_cnt + CNT_W'(1);

      if (r_fall && w_active) r_high <= r_cnt;

      case (r_state)
        ST_IDLE: begin
          if (r_rise) begin
            r_state <= ST_MEASURE;
            r_match <= '0;
          end
        end
        ST_MEASURE: begin
          if (r_rise) begin
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            if (w_exp_zero || !w_match) begin
              r_match <= '0;
            end else if (w_lock_hit) begin
              r_match  <= r_match + CNT_W'(1);
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_match <= r_match + CNT_W'(1);
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_match <= '0;
          end
        end
        ST_LOCKED: begin
          if (r_rise) begin
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            if (w_exp_zero || !w_match) begin
              r_state  <= ST_MEASURE;
              r_locked <= 1'b0;
              r_match  <= '0;
            end
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_match  <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
          r_match  <= '0;
        end
      endcase
    end
  end

  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign period       = r_period;
  assign high_cnt     = r_high;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign err          = r_err;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench: the driver predicts each measured period from its own
// rise timestamps; a negedge monitor pops predictions on period_valid.
module tb_clk_div_monitor;

  localparam int unsigned S      = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LOCK   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             div_clk_in = 1'b0;
  logic [CNT_W-1:0] expected_period = '0;
  logic             clear = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, locked, err;
  logic [CNT_W-1:0] period, high_cnt, err_count;

  clk_div_monitor #(.SYNC_STAGES(S), .CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .div_clk_in      (div_clk_in),
    .expected_period (expected_period),
    .clear           (clear),
    .rise_pulse      (rise_pulse),
    .fall_pulse      (fall_pulse),
    .period          (period),
    .high_cnt        (high_cnt),
    .period_valid    (period_valid),
    .locked          (locked),
    .err             (err),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    bit err;
    bit locked;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state, in driver cycle units
  bit m_seen;
  int m_t, m_last_rise, m_match, m_errs, m_high;
  bit m_locked;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int all_outs();
    return int'({rise_pulse, fall_pulse, period, high_cnt, period_valid, locked, err, err_count});
  endfunction

  task automatic tick();
    @(negedge clk);
    m_t++;
  endtask

  task automatic model_reset();
    q.delete();
    m_seen = 1'b0; m_t = 0; m_last_rise = 0; m_match = 0;
    m_errs = 0; m_high = 0; m_locked = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    div_clk_in = 1'b0;
    clear      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Every rise after the first closes a period whose length is the gap between rises.
  task automatic model_rise();
    exp_t e;
    int   gap;
    if (m_seen) begin
      gap   = m_t - m_last_rise;
      e.err = (expected_period != 0) && (gap != int'(expected_period));
      if (e.err) begin
        m_match = 0;
        if (m_errs < 255) m_errs++;
      end else if (expected_period != 0) begin
        m_match++;
      end else begin
        m_match = 0;
      end
      m_locked = (m_match >= int'(LOCK));
      e.period = gap;
      e.high   = m_high;
      e.locked = m_locked;
      q.push_back(e);
    end
    m_seen      = 1'b1;
    m_last_rise = m_t;
  endtask

  task automatic drive_period(input int per, input int hi);
    div_clk_in = 1'b1;
    model_rise();
    repeat (hi) tick();
    div_clk_in = 1'b0;
    m_high = hi;
    repeat (per - hi) tick();
  endtask

  task automatic drive_wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) drive_period(per, hi);
  endtask

  task automatic drive_rand(input int n, input int base, input int hi);
    int per, h;
    for (int i = 0; i < n; i++) begin
      per = ($urandom_range(0, 3) == 0) ? base + 1 : base;
      h   = (hi < per) ? hi : per - 1;
      drive_period(per, h);
    end
  endtask

  task automatic drain();
    repeat (10) tick();
    check("queue_drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_en) begin
      if (period_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got period %0d expected no valid", period);
        end else begin
          e = q.pop_front();
          check("period", int'(period), e.period);
          check("high_cnt", int'(high_cnt), e.high);
          check("err_on_valid", int'(err), int'(e.err));
          check("locked_on_valid", int'(locked), int'(e.locked));
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err: got err 1 expected 0");
      end
    end
  end

  initial begin
    int k, p, hi, sel, cnt, found, ec;

    // Reset state and rise latency through the synchronizer
    do_reset();
    check("reset_state", all_outs(), 0);
    div_clk_in = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rise_pulse) begin k = i; break; end
    end
    check("rise_latency", k, int'(S) + 1);

    // Divide-by-3 locks after four valid periods, then stuck-low timeout
    do_reset();
    expected_period = 8'd3;
    mon_en = 1'b1;
    drive_wave(3, 1, 8);
    drain();
    check("div3_locked", int'(locked), 1);
    check("div3_err_count", int'(err_count), 0);
    mon_en = 1'b0;
    ec  = int'(err_count);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) cnt++;
    end
    check("timeout_err_pulses", cnt, 1);
    check("timeout_unlocked", int'(locked), 0);
    check("timeout_err_count", int'(err_count), ec + 1);

    // Asynchronous reset mid-run, then relock from scratch
    do_reset();
    expected_period = 8'd3;
    mon_en = 1'b1;
    drive_wave(3, 2, 6);
    drain();
    check("pre_reset_locked", int'(locked), 1);
    mon_en = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    drive_wave(3, 2, 7);
    drain();
    check("relocked", int'(locked), 1);

    // Divide-by-4 against expected 3: err every period
    do_reset();
    expected_period = 8'd3;
    mon_en = 1'b1;
    drive_wave(4, 2, 6);
    drain();
    check("div4_err_count", int'(err_count), 5);
    check("div4_never_locked", int'(locked), 0);

    // Expected period 0: measure only
    do_reset();
    expected_period = 8'd0;
    mon_en = 1'b1;
    drive_wave(4, 2, 8);
    drain();
    check("exp0_locked", int'(locked), 0);
    check("exp0_err_count", int'(err_count), 0);

    // Clear coincident with a mismatching rise
    do_reset();
    expected_period = 8'd3;
    mon_en = 1'b1;
    drive_wave(3, 1, 6);
    drain();
    check("pre_clear_locked", int'(locked), 1);
    mon_en = 1'b0;
    expected_period = 8'd5;
    div_clk_in = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rise_pulse) begin found = 1; break; end
    end
    check("clear_rise_seen", found, 1);
    clear = 1'b1;
    @(negedge clk);
    check("clear_err", int'(err), 0);
    check("clear_err_count", int'(err_count), 0);
    check("clear_locked", int'(locked), 0);
    check("clear_valid", int'(period_valid), 0);
    check("clear_period", int'(period), 0);
    clear = 1'b0;
    div_clk_in = 1'b0;

    // Randomized phases with occasional period jitter
    for (int ph = 0; ph < 6; ph++) begin
      do_reset();
      p   = $urandom_range(2, 9);
      hi  = $urandom_range(1, p - 1);
      sel = $urandom_range(0, 3);
      expected_period = (sel == 0) ? 8'd0 : (sel == 1) ? CNT_W'(p + 1) : CNT_W'(p);
      mon_en = 1'b1;
      drive_rand(12, p, hi);
      drain();
      check("rand_err_count", int'(err_count), m_errs);
      check("rand_locked", int'(locked), int'(m_locked));
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on div_clk_in (legal 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of all period/phase counters.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4, number of consecutive matching periods required to lock.
REQ-004 clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 div_clk_in  input  1  divided clock under observation, e.g. odd_divider_3 from clock_divider; treated as asynchronous.
REQ-007 expected_period  input  CNT_W  expected rise-to-rise period in clk cycles; 0 disables locking.
REQ-008 clear  input  1  synchronous soft clear of FSM, counters and flags.
REQ-009 rise_pulse  output  1  one-cycle pulse per detected div_clk rising edge.
REQ-010 fall_pulse  output  1  one-cycle pulse per detected div_clk falling edge.
REQ-011 period  output  CNT_W  last measured rise-to-rise period, clk cycles.
REQ-012 high_cnt  output  CNT_W  last measured high phase (rise to fall), clk cycles.
REQ-013 period_valid  output  1  one-cycle pulse when period/high_cnt update.
REQ-014 locked  output  1  high while in LOCKED state.
REQ-015 err  output  1  one-cycle pulse on period mismatch or timeout.
REQ-016 err_count  output  CNT_W  saturating count of err pulses.

Function
REQ-017 div_clk_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; if first sampled 1 at posedge t0, rise_pulse SHALL be 1 in the cycle after posedge t0+SYNC_STAGES (same rule for fall_pulse on 1->0).
REQ-018 A free-running counter SHALL load 1 on rise_pulse and increment otherwise, saturating at 2^CNT_W-1.
REQ-019 On each rise_pulse except the first after reset/clear/timeout, period SHALL take the counter value and period_valid SHALL pulse in the same cycle; a constant divide-by-N input SHALL give period = N.
REQ-020 On fall_pulse, high_cnt SHALL take the counter value (phase since last rise); the first fall before any rise SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, MEASURE, LOCKED.
REQ-022 IDLE -> MEASURE on first rise_pulse; no period_valid in this transition.
REQ-023 MEASURE: a matching period (period == expected_period, nonzero) SHALL increment a match counter; a mismatch SHALL reset it to 0 and pulse err; match counter reaching LOCK_CNT SHALL go to LOCKED.
REQ-024 LOCKED: a mismatching period SHALL pulse err, deassert locked next cycle, and return to MEASURE with match counter 0.
REQ-025 Timeout: counter reaching saturation in MEASURE or LOCKED SHALL pulse err once and go to IDLE (stuck clock); in IDLE no timeout err.
REQ-026 expected_period == 0: every period counts as mismatch-free but match counter SHALL stay 0, so locked never asserts and err never pulses on period.
REQ-027 err_count SHALL increment on each err pulse and hold at 2^CNT_W-1.
REQ-028 clear SHALL have priority over every other event in the same cycle; state returns to IDLE, all outputs to reset values next cycle; synchronizer flops are not cleared.

Reset
REQ-029 On rst_n low: synchronizer and edge flops 0, FSM IDLE, counters 0, period 0, high_cnt 0, all pulses 0, locked 0, err_count 0.
REQ-030 Reset assertion mid-measurement SHALL take effect immediately; after release the block SHALL behave as from power-up (first rise ignored for period).

Structure
REQ-031 Package clk_div_monitor_pkg SHALL hold the state enum (IDLE, MEASURE, LOCKED) and default CNT_W/LOCK_CNT constants.
REQ-032 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, asynchronous active-low reset to 0).

Verification
REQ-033 Divide-by-3 input, expected_period 3 -> period_valid each 3 cycles with period 3; locked after 4th valid period; err_count 0.
REQ-034 Divide-by-4 input, expected_period 3 -> err pulse on every period_valid, locked stays 0, err_count increments per period.
REQ-035 Locked on divide-by-3, then input held low -> err once after counter hits 255, state IDLE, locked 0.
REQ-036 Locked on divide-by-3, rst_n pulsed low mid-period -> all outputs 0 immediately; relock after 1+4 rises post release.
REQ-037 clear asserted in same cycle as a mismatching rise_pulse -> no err, err_count unchanged, state IDLE.
REQ-038 Divide-by-4 50% duty -> high_cnt 2, period 4; expected_period 0 -> locked never, err never.
